// File: rtl/orao_video_pkg.sv
// Shared constants for the Orao video front end: default 640x480@60 timing,
// Orao window geometry and a span-decode helper used by the raster decode.
package orao_video_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int ORAO_W         = 256;
  localparam int ORAO_H         = 256;
  localparam int BYTES_PER_LINE = 32;
  localparam int ADDR_W         = 13;
  localparam int CNT_W          = 10;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [CNT_W-1:0] count_t;

  // True when value lies in [start, start+len)
  function automatic logic in_span(input count_t value, input int start, input int len);
    return (value >= CNT_W'(start)) && (value < CNT_W'(start + len));
  endfunction

endpackage

// File: rtl/orao_video_timing.sv
// Raster counters plus registered sync/enable/frame_start; exposes the
// live counters and the Orao window flags to the fetch pipeline.
module orao_video_timing
  import orao_video_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int X0        = 192,
  parameter int Y0        = 112
) (
  input  logic       clk_pixel,
  input  logic       reset,
  output count_t     hcount,
  output count_t     vcount,
  output logic       in_win,
  output logic       win_line,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  count_t hcount_r;
  count_t vcount_r;
  logic   h_last_s;
  logic   v_last_s;
  logic   hs_act_s;
  logic   vs_act_s;
  logic   de_s;
  logic   win_col_s;

  // Decode of the current counter position
  always_comb begin
    h_last_s  = (hcount_r == CNT_W'(H_TOT - 1));
    v_last_s  = (vcount_r == CNT_W'(V_TOT - 1));
    hs_act_s  = in_span(hcount_r, H_VISIBLE + H_FRONT, H_SYNC);
    vs_act_s  = in_span(vcount_r, V_VISIBLE + V_FRONT, V_SYNC);
    de_s      = (hcount_r < CNT_W'(H_VISIBLE)) && (vcount_r < CNT_W'(V_VISIBLE));
    win_col_s = in_span(hcount_r, X0, ORAO_W);
    win_line  = in_span(vcount_r, Y0, ORAO_H);
    in_win    = win_col_s && win_line;
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hcount_r <= '0;
      vcount_r <= '0;
    end else if (h_last_s) begin
      hcount_r <= '0;
      vcount_r <= v_last_s ? '0 : vcount_r + CNT_W'(1);
    end else begin
      hcount_r <= hcount_r + CNT_W'(1);
    end
  end

  // Registered outputs describe the position held before this edge
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_act_s ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= vs_act_s ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      de          <= de_s;
      frame_start <= (hcount_r == '0) && (vcount_r == '0);
    end
  end

  assign hcount = hcount_r;
  assign vcount = vcount_r;

endmodule

// File: rtl/orao_video_fetch.sv
// Orao video fetch: issues 32 byte addresses per window line, captures the
// returned bytes and shifts them out LSB-first as 1-bit pixels.
module orao_video_fetch
  import orao_video_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int X0        = 192,
  parameter int Y0        = 112,
  parameter int INVERT    = 0
) (
  input  logic              clk_pixel,
  input  logic              reset,
  output logic [ADDR_W-1:0] dispAddr,
  input  logic [7:0]        dispData,
  output logic              pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  // Address goes out three clocks ahead of the byte's first pixel
  localparam int   FETCH_START = X0 - 3;
  localparam int   FETCH_SPAN  = BYTES_PER_LINE * 8;
  localparam logic INV_BIT     = (INVERT != 0) ? 1'b1 : 1'b0;

  count_t     hcount_s;
  count_t     vcount_s;
  logic       in_win_s;
  logic       win_line_s;
  count_t     fetch_h_s;
  logic       fetch_span_s;
  logic       issue_s;
  logic       load_s;
  logic [4:0] byte_idx_s;
  logic [7:0] y_rel_s;
  logic [7:0] shift_r;

  orao_video_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .X0        (X0),
    .Y0        (Y0)
  ) u_timing (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .hcount      (hcount_s),
    .vcount      (vcount_s),
    .in_win      (in_win_s),
    .win_line    (win_line_s),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start)
  );

  // Fetch slot decode: slot 0 issues the address, slot 2 captures the byte
  always_comb begin
    fetch_h_s    = hcount_s - CNT_W'(FETCH_START);
    fetch_span_s = win_line_s && in_span(hcount_s, FETCH_START, FETCH_SPAN);
    issue_s      = fetch_span_s && (fetch_h_s[2:0] == 3'd0);
    load_s       = fetch_span_s && (fetch_h_s[2:0] == 3'd2);
    byte_idx_s   = fetch_h_s[7:3];
    y_rel_s      = 8'(vcount_s - CNT_W'(Y0));
  end

  // Address sequencing, byte shifter and pixel register
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      dispAddr <= '0;
      shift_r  <= 8'h00;
      pixel    <= 1'b0;
    end else begin
      if (issue_s) begin
        dispAddr <= {y_rel_s, byte_idx_s};
      end
      if (load_s) begin
        shift_r <= dispData;
      end else if (in_win_s) begin
        shift_r <= {1'b0, shift_r[7:1]};
      end
      pixel <= in_win_s ? (shift_r[0] ^ INV_BIT) : 1'b0;
    end
  end

endmodule
